hamming_code_7_3_corrector: RTL and testbench

Streaming single-error-correcting decoder for the 7-bit codewords produced by the team's Hamming (7,4) generator; sits directly downstream of it on the receive side of a link or storage path. Each accepted codeword is checked, any single-bit error is corrected, and the 4 data bits are delivered with error flags. Processing uses a 2-stage registered pipeline with valid/ready flow control on both sides. Saturating statistics counters record corrected codewords.

---
 rtl/hamming_code_7_3_corrector_if.sv | 39 +++
 rtl/hamming_code_7_3_corrector.sv | 107 ++++++++++
 tb/tb_hamming_code_7_3_corrector.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hamming_code_7_3_corrector_if.sv
// Stream bundle for the Hamming (7,4) corrector.
// Carries the receive-side codeword handshake and the corrected output handshake.
interface hamming_code_7_3_corrector_if;
    // Input side, from the codeword source.
    logic       in_valid;
    logic       in_ready;
    logic [6:0] code_in;

    // Output side, to the data sink.
    logic       out_valid;
    logic       out_ready;
    logic [3:0] data_out;
    logic [2:0] syndrome;
    logic       err;

    // View from the environment that drives codewords and sinks data.
    modport master (
        output in_valid,
        output code_in,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  data_out,
        input  syndrome,
        input  err
    );

    // View from the corrector itself.
    modport slave (
        input  in_valid,
        input  code_in,
        output in_ready,
        output out_valid,
        input  out_ready,
        output data_out,
        output syndrome,
        output err
    );
endinterface

// File: rtl/hamming_code_7_3_corrector.sv
// Two-stage streaming single-error-correcting decoder for Hamming (7,4) codewords.
// S1 holds the received codeword and its syndrome; S2 holds the corrected data and
// drives the outputs. A saturating counter tracks delivered codewords that were corrected.
module hamming_code_7_3_corrector #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    hamming_code_7_3_corrector_if.slave bus,
    input  logic                      cnt_clr,
    output logic [CNT_W-1:0]          corr_cnt
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic       s1_valid;
    logic [6:0] s1_code;
    logic [2:0] s1_syn;

    logic       s2_valid;
    logic [3:0] s2_data;
    logic [2:0] s2_syn;
    logic       s2_err;

    logic       s1_load;
    logic       s2_load;
    logic [2:0] in_syn;
    logic [6:0] flip_mask;
    logic [6:0] corrected;

    // Stage advance: S2 drains when empty or accepted; S1 refills whenever S2 makes room.
    always_comb begin
        s2_load     = !s2_valid || bus.out_ready;
        s1_load     = !s1_valid || s2_load;
        bus.in_ready = s1_load;
    end

    // Syndrome of the incoming codeword, c6..c0.
    always_comb begin
        in_syn[2] = bus.code_in[6] ^ bus.code_in[5] ^ bus.code_in[4] ^ bus.code_in[2];
        in_syn[1] = bus.code_in[6] ^ bus.code_in[5] ^ bus.code_in[3] ^ bus.code_in[1];
        in_syn[0] = bus.code_in[6] ^ bus.code_in[4] ^ bus.code_in[3] ^ bus.code_in[0];
    end

    // Map the registered syndrome to the single bit to invert; any nonzero value is
    // taken as a single-bit error, so double errors are knowingly miscorrected.
    always_comb begin
        flip_mask = 7'b000_0000;
        unique case (s1_syn)
            3'd7:    flip_mask = 7'b100_0000;
            3'd6:    flip_mask = 7'b010_0000;
            3'd5:    flip_mask = 7'b001_0000;
            3'd3:    flip_mask = 7'b000_1000;
            3'd4:    flip_mask = 7'b000_0100;
            3'd2:    flip_mask = 7'b000_0010;
            3'd1:    flip_mask = 7'b000_0001;
            default: flip_mask = 7'b000_0000;
        endcase
        corrected = s1_code ^ flip_mask;
    end

    // Stage 1 register: received codeword and its syndrome.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_code  <= 7'd0;
            s1_syn   <= 3'd0;
        end else if (s1_load) begin
            s1_valid <= bus.in_valid;
            s1_code  <= bus.code_in;
            s1_syn   <= in_syn;
        end
    end

    // Stage 2 register: corrected data with its syndrome and error flag, held while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= 4'd0;
            s2_syn   <= 3'd0;
            s2_err   <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            s2_data  <= corrected[6:3];
            s2_syn   <= s1_syn;
            s2_err   <= (s1_syn != 3'd0);
        end
    end

    // Outputs come straight from the S2 registers.
    always_comb begin
        bus.out_valid = s2_valid;
        bus.data_out  = s2_data;
        bus.syndrome  = s2_syn;
        bus.err       = s2_err;
    end

    // Corrected-codeword counter: counts erroneous output transfers, saturates, clear wins.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            corr_cnt <= '0;
        end else if (s2_valid && bus.out_ready && s2_err && (corr_cnt != CntMax)) begin
            corr_cnt <= corr_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hamming_code_7_3_corrector.sv
// Directed self-checking bench for hamming_code_7_3_corrector.
// A default-width instance covers decoding, flow control and reset; a CNT_W=2 instance
// covers counter saturation and clear priority.
module tb_hamming_code_7_3_corrector;

    logic       clk = 1'b0;
    logic       rst;
    logic       cnt_clr;
    logic       cnt_clr2;
    logic [15:0] corr_cnt;
    logic [1:0]  corr_cnt2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hamming_code_7_3_corrector_if bus ();
    hamming_code_7_3_corrector_if bus2 ();

    hamming_code_7_3_corrector #(.CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .cnt_clr  (cnt_clr),
        .corr_cnt (corr_cnt)
    );

    hamming_code_7_3_corrector #(.CNT_W(2)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus2),
        .cnt_clr  (cnt_clr2),
        .corr_cnt (corr_cnt2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference encoder, parity bits written out from the codeword definition.
    function automatic logic [6:0] enc(input logic [3:0] d);
        return {d, d[3] ^ d[2] ^ d[1], d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0]};
    endfunction

    // Expected syndrome when bit k of the codeword is flipped.
    function automatic logic [2:0] syn_of_bit(input int k);
        case (k)
            6: return 3'd7;
            5: return 3'd6;
            4: return 3'd5;
            3: return 3'd3;
            2: return 3'd4;
            1: return 3'd2;
            0: return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

    // Push one codeword through the main instance with out_ready held high.
    task automatic send_one(input string tag, input logic [6:0] code, input logic [3:0] d,
                            input logic [2:0] s, input logic e);
        int waits;
        @(negedge clk);
        bus.code_in   = code;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check_eq({tag, "_not_yet"}, {31'd0, bus.out_valid}, 32'd0);
        waits = 0;
        while (!bus.out_valid && waits < 4) begin
            @(negedge clk);
            waits++;
        end
        check_eq({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check_eq({tag, "_data"}, {28'd0, bus.data_out}, {28'd0, d});
        check_eq({tag, "_syn"}, {29'd0, bus.syndrome}, {29'd0, s});
        check_eq({tag, "_err"}, {31'd0, bus.err}, {31'd0, e});
        @(negedge clk);
    endtask

    initial begin
        logic [6:0]  exp_code [16];
        logic [3:0]  exp_data [16];
        logic        exp_err  [16];
        logic [31:0] pattern;
        int          idx_in;
        int          idx_out;
        int          occ;
        logic        prev_stall;
        logic [3:0]  prev_data;
        logic        seen;

        rst = 1'b1;
        cnt_clr = 1'b0;
        cnt_clr2 = 1'b0;
        bus.in_valid = 1'b0;
        bus.code_in = 7'd0;
        bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0;
        bus2.code_in = 7'd0;
        bus2.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset state.
        check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("rst_data", {28'd0, bus.data_out}, 32'd0);
        check_eq("rst_syn", {29'd0, bus.syndrome}, 32'd0);
        check_eq("rst_err", {31'd0, bus.err}, 32'd0);
        check_eq("rst_cnt", {16'd0, corr_cnt}, 32'd0);
        check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Saturation on the narrow counter: five erroneous codewords streamed back to back.
        @(negedge clk);
        bus2.out_ready = 1'b1;
        bus2.in_valid  = 1'b1;
        bus2.code_in   = 7'b1011000;
        repeat (5) @(negedge clk);
        bus2.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("cnt2_saturate", {30'd0, corr_cnt2}, 32'd3);

        // Clear coinciding with an erroneous output transfer.
        bus2.in_valid = 1'b1;
        @(negedge clk);
        bus2.in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            seen = bus2.out_valid;
        end
        check_eq("cnt2_clr_valid", {31'd0, seen}, 32'd1);
        check_eq("cnt2_clr_err", {31'd0, bus2.err}, 32'd1);
        cnt_clr2 = 1'b1;
        @(negedge clk);
        cnt_clr2 = 1'b0;
        check_eq("cnt2_clr_wins", {30'd0, corr_cnt2}, 32'd0);

        // Directed decode vectors.
        send_one("noerr", 7'b1011001, 4'b1011, 3'b000, 1'b0);
        check_eq("noerr_cnt", {16'd0, corr_cnt}, 32'd0);
        send_one("err_c5", 7'b1111001, 4'b1011, 3'b110, 1'b1);
        check_eq("err_c5_cnt", {16'd0, corr_cnt}, 32'd1);
        send_one("err_c0", 7'b1011000, 4'b1011, 3'b001, 1'b1);
        check_eq("err_c0_cnt", {16'd0, corr_cnt}, 32'd2);

        // Every single-bit flip of every data value.
        for (int d = 0; d < 16; d++) begin
            for (int k = 0; k < 7; k++) begin
                send_one($sformatf("walk_d%0d_b%0d", d, k), enc(4'(d)) ^ (7'd1 << k),
                         4'(d), syn_of_bit(k), 1'b1);
            end
        end
        check_eq("walk_cnt", {16'd0, corr_cnt}, 32'd114);

        // Back-pressure stream: ordering, no loss/duplication, stall stability, full => !in_ready.
        for (int i = 0; i < 16; i++) begin
            exp_data[i] = 4'(i);
            exp_err[i]  = (i % 8) < 7;
            exp_code[i] = exp_err[i] ? (enc(4'(i)) ^ (7'd1 << (i % 8))) : enc(4'(i));
        end
        pattern    = 32'hB3A5_6C91;
        idx_in     = 0;
        idx_out    = 0;
        prev_stall = 1'b0;
        prev_data  = 4'd0;
        for (int cyc = 0; cyc < 200 && idx_out < 16; cyc++) begin
            @(negedge clk);
            bus.out_ready = pattern[cyc % 32];
            bus.in_valid  = (idx_in < 16);
            bus.code_in   = (idx_in < 16) ? exp_code[idx_in] : 7'd0;
            #1;
            occ = idx_in - idx_out;
            check_eq($sformatf("bp_in_ready_c%0d", cyc), {31'd0, bus.in_ready},
                     {31'd0, !(occ == 2 && !bus.out_ready)});
            if (prev_stall) begin
                check_eq($sformatf("bp_hold_valid_c%0d", cyc), {31'd0, bus.out_valid}, 32'd1);
                check_eq($sformatf("bp_hold_data_c%0d", cyc), {28'd0, bus.data_out},
                         {28'd0, prev_data});
            end
            if (bus.out_valid) begin
                check_eq($sformatf("bp_data_%0d", idx_out), {28'd0, bus.data_out},
                         {28'd0, exp_data[idx_out]});
                check_eq($sformatf("bp_err_%0d", idx_out), {31'd0, bus.err},
                         {31'd0, exp_err[idx_out]});
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.data_out;
            if (bus.out_valid && bus.out_ready) idx_out++;
            if (bus.in_valid && bus.in_ready) idx_in++;
        end
        check_eq("bp_all_out", idx_out, 32'd16);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        // 114 before the stream plus 14 erroneous codewords in it.
        check_eq("bp_cnt", {16'd0, corr_cnt}, 32'd128);

        // Clear on the wide counter.
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        check_eq("cnt_clr", {16'd0, corr_cnt}, 32'd0);
        send_one("pre_rst", 7'b1111001, 4'b1011, 3'b110, 1'b1);

        // Reset mid-stream with two codewords in flight.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.code_in   = 7'b0101010;
        @(negedge clk);
        bus.code_in = 7'b1111111;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check_eq("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("mid_rst_cnt", {16'd0, corr_cnt}, 32'd0);
        check_eq("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | bus.out_valid;
        end
        check_eq("mid_rst_no_emit", {31'd0, seen}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
